// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage. Owns the fetch PC, issues in-order
// word fetches, buffers returned words and hands {inst, inst_pc} to decode.
// Redirects flush buffered and in-flight fetches; stale responses are counted
// off through a drop counter.
// Optional feature macro: IFETCH_MISALIGN_CHK_EN (misaligned-redirect check).
//
// state  | meaning
// run    | normal fetching (misalign_err=0)
// halt   | misaligned redirect seen, requests blocked until an aligned redirect
//          (only exists when IFETCH_MISALIGN_CHK_EN is defined)
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign_err
);

  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [31:0] fetch_pc;
  logic [31:0] q_inst [FQ_DEPTH];
  logic [31:0] q_pc   [FQ_DEPTH];
  logic [PW-1:0] q_rd, q_wr;
  logic [CW-1:0] q_cnt;
  logic [31:0] t_pc   [FQ_DEPTH];
  logic [PW-1:0] t_rd, t_wr;
  logic [CW-1:0] outstanding;
  logic [15:0]   drop;

  logic        pop, room, halted, req_fire, rsp_drop, rsp_take;
  logic [31:0] pc_tgt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef IFETCH_MISALIGN_CHK_EN
  logic misalign_q;
  assign halted       = misalign_q;
  assign misalign_err = misalign_q;
`else
  logic unused_low;
  assign unused_low   = ^redirect_pc[1:0];
  assign halted       = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign pc_tgt = {redirect_pc[31:2], 2'b00};

  // Head of the queue to decode; NOP and PC 0 when nothing is buffered.
  always_comb begin
    inst_valid = (q_cnt != '0);
    inst       = inst_valid ? q_inst[q_rd] : NOP_INST;
    inst_pc    = inst_valid ? q_pc[q_rd] : 32'h0;
  end

  // Request gating: the entry being popped this cycle frees its slot, so a
  // 1-cycle memory can keep decode fed every cycle with two entries.
  always_comb begin
    pop            = inst_valid && inst_ready;
    room           = (({1'b0, q_cnt} - (CW+1)'(pop) + {1'b0, outstanding})
                      < (CW+1)'(FQ_DEPTH));
    imem_req_valid = rst_n && !redirect_valid && room && !halted;
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop != 16'd0);
    rsp_take       = imem_rsp_valid && (drop == 16'd0) && !redirect_valid;
  end

  // PC, tag FIFO, instruction queue and drop bookkeeping; redirect wins over all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      q_rd        <= '0;
      q_wr        <= '0;
      q_cnt       <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
      outstanding <= '0;
      drop        <= 16'd0;
`ifdef IFETCH_MISALIGN_CHK_EN
      misalign_q  <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // Any response arriving now is discarded, whether it was stale or live.
      fetch_pc    <= pc_tgt;
      q_rd        <= '0;
      q_wr        <= '0;
      q_cnt       <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
      outstanding <= '0;
      drop        <= drop + 16'(outstanding) - 16'(imem_rsp_valid);
`ifdef IFETCH_MISALIGN_CHK_EN
      misalign_q  <= (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (req_fire) begin
        t_pc[t_wr] <= fetch_pc;
        t_wr       <= ptr_inc(t_wr);
        fetch_pc   <= fetch_pc + 32'd4;
      end
      if (rsp_drop) drop <= drop - 16'd1;
      if (rsp_take) begin
        q_inst[q_wr] <= imem_rsp_data;
        q_pc[q_wr]   <= t_pc[t_rd];
        q_wr         <= ptr_inc(q_wr);
        t_rd         <= ptr_inc(t_rd);
      end
      if (pop) q_rd <= ptr_inc(q_rd);
      q_cnt       <= q_cnt + CW'(rsp_take) - CW'(pop);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
    end
  end

endmodule
